// File: rtl/pattern_tx.sv
// Serial pattern transmitter: captures an up-to-8-bit word and shifts it out LSB first.
// Optional run-length monitor enabled by defining PATTERN_TX_RUNLEN_EN.
module pattern_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [3:0] len,
    output logic       w,
    output logic       w_valid,
    output logic       busy,
    output logic       done,
    output logic [1:0] txState,
    output logic [3:0] run_len,
    output logic       run_hit
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t     state;
    logic [7:0] dreg;
    logic [3:0] lreg;
    logic [2:0] idx;
    logic [3:0] len_c;
    logic [2:0] nidx;
    logic       nbit;
    logic       last;

    assign len_c   = (len > 4'd8) ? 4'd8 : len;
    // nidx only wraps on the last bit, where it is not used
    assign nidx    = idx + 3'd1;
    assign nbit    = dreg[nidx];
    assign last    = ({1'b0, idx} == (lreg - 4'd1));
    assign txState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dreg    <= '0;
            lreg    <= '0;
            idx     <= '0;
            w       <= 1'b0;
            w_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && len != 4'd0) begin
                        state <= LOAD;
                        dreg  <= data;
                        lreg  <= len_c;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= SHIFT;
                    idx     <= '0;
                    w       <= dreg[0];
                    w_valid <= 1'b1;
                end
                SHIFT: begin
                    if (last) begin
                        state   <= DONE;
                        w       <= 1'b0;
                        w_valid <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        idx <= nidx;
                        w   <= nbit;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PATTERN_TX_RUNLEN_EN
    // w still holds the previous SHIFT bit when the next one is chosen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len <= '0;
            run_hit <= 1'b0;
        end else if (state == LOAD) begin
            run_len <= 4'd1;
            run_hit <= 1'b0;
        end else if (state == SHIFT && !last) begin
            if (nbit == w) begin
                run_len <= (run_len == 4'd15) ? 4'd15 : run_len + 4'd1;
                run_hit <= 1'b1;
            end else begin
                run_len <= 4'd1;
                run_hit <= 1'b0;
            end
        end else begin
            run_len <= '0;
            run_hit <= 1'b0;
        end
    end
`else
    assign run_len = 4'd0;
    assign run_hit = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized self-checking bench for pattern_tx against a per-cycle behavioural model.
module tb_pattern_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] len = '0;
    logic       w, w_valid, busy, done;
    logic [1:0] txState;
    logic [3:0] run_len;
    logic       run_hit;

    int tests = 0;
    int fails = 0;

    logic [10:0] obs [0:11];
    int          nobs;

    pattern_tx dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
        .w(w), .w_valid(w_valid), .busy(busy), .done(done),
        .txState(txState), .run_len(run_len), .run_hit(run_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pack_out();
        return {txState, w, w_valid, busy, done, run_len, run_hit};
    endfunction

    // Expected outputs n cycles after the start edge: {state,w,valid,busy,done,run_len,run_hit}
    function automatic logic [10:0] model(input logic [7:0] d, input int l, input int n);
        int L, k, rl;
        logic b;
        L = (l > 8) ? 8 : l;
        if (L == 0) return '0;
        if (n == 0) return {2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
        if (n >= 1 && n <= L) begin
            k  = n - 1;
            b  = d[k];
            rl = 1;
            for (int j = k; j > 0 && d[j-1] == b; j--) rl++;
            if (rl > 15) rl = 15;
`ifdef PATTERN_TX_RUNLEN_EN
            return {2'b10, b, 1'b1, 1'b1, 1'b0, 4'(rl), rl >= 2};
`else
            return {2'b10, b, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
`endif
        end
        if (n == L + 1) return {2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0};
        return '0;
    endfunction

    // Called at a negedge; issues start and records outputs for each following cycle.
    task automatic xfer(input logic [7:0] d, input logic [3:0] l, input bit hold, input bit scramble);
        int L;
        L     = (l > 8) ? 8 : int'(l);
        nobs  = (L == 0) ? 3 : L + 3;
        start = 1'b1;
        data  = d;
        len   = l;
        for (int n = 0; n < nobs; n++) begin
            @(negedge clk);
            obs[n] = pack_out();
            if (!hold) start = 1'b0;
            if (scramble) begin
                data = 8'($urandom);
                len  = 4'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests++;
        if (pack_out() !== 11'd0) begin
            fails++;
            $display("FAIL reset_init: got %b want %b", pack_out(), 11'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        data  = 8'hFF;
        len   = 4'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (txState !== 2'b10) begin
            fails++;
            $display("FAIL reset_pre_shift: state %b want %b", txState, 2'b10);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (pack_out() !== 11'd0) begin
            fails++;
            $display("FAIL reset_async: got %b want %b", pack_out(), 11'd0);
        end
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (pack_out() !== 11'd0) begin
                fails++;
                $display("FAIL reset_hold: got %b want %b", pack_out(), 11'd0);
            end
        end
        reset = 1'b1;
        xfer(8'hA5, 4'd4, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'hA5, 4, n)) begin
                fails++;
                $display("FAIL reset_restart c%0d: got %b want %b", n, obs[n], model(8'hA5, 4, n));
            end
        end
    endtask

    task automatic test_basic();
        int busy_cnt;
        xfer(8'b1011_0010, 4'd8, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int n = 0; n < nobs; n++) begin
            busy_cnt += int'(obs[n][6]);
            tests++;
            if (obs[n] !== model(8'b1011_0010, 8, n)) begin
                fails++;
                $display("FAIL basic c%0d: got %b want %b", n, obs[n], model(8'b1011_0010, 8, n));
            end
        end
        tests++;
        if (busy_cnt != 10) begin
            fails++;
            $display("FAIL basic_busy_len: got %0d want 10", busy_cnt);
        end
    endtask

    task automatic test_clamp();
        xfer(8'h05, 4'd3, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'h05, 3, n)) begin
                fails++;
                $display("FAIL short c%0d: got %b want %b", n, obs[n], model(8'h05, 3, n));
            end
        end
        xfer(8'h0F, 4'd12, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'h0F, 12, n)) begin
                fails++;
                $display("FAIL clamp c%0d: got %b want %b", n, obs[n], model(8'h0F, 12, n));
            end
        end
    endtask

    task automatic test_noop();
        xfer(8'hFF, 4'd0, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== 11'd0) begin
                fails++;
                $display("FAIL noop c%0d: got %b want %b", n, obs[n], 11'd0);
            end
        end
    endtask

    task automatic test_back_to_back();
        xfer(8'h3C, 4'd5, 1'b1, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'h3C, 5, n)) begin
                fails++;
                $display("FAIL b2b_first c%0d: got %b want %b", n, obs[n], model(8'h3C, 5, n));
            end
        end
        xfer(8'hC9, 4'd6, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'hC9, 6, n)) begin
                fails++;
                $display("FAIL b2b_second c%0d: got %b want %b", n, obs[n], model(8'hC9, 6, n));
            end
        end
    endtask

    task automatic test_capture();
        xfer(8'b0110_1001, 4'd8, 1'b0, 1'b1);
        data = '0;
        len  = '0;
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'b0110_1001, 8, n)) begin
                fails++;
                $display("FAIL capture c%0d: got %b want %b", n, obs[n], model(8'b0110_1001, 8, n));
            end
        end
    endtask

    task automatic test_runlen();
        xfer(8'b0000_0111, 4'd8, 1'b0, 1'b0);
        for (int n = 0; n < nobs; n++) begin
            tests++;
            if (obs[n] !== model(8'b0000_0111, 8, n)) begin
                fails++;
                $display("FAIL runlen c%0d: got %b want %b", n, obs[n], model(8'b0000_0111, 8, n));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [3:0] l;
        bit         scr;
        for (int t = 0; t < 30; t++) begin
            d   = 8'($urandom);
            l   = 4'($urandom_range(0, 15));
            scr = 1'($urandom);
            xfer(d, l, 1'b0, scr);
            data = '0;
            len  = '0;
            for (int n = 0; n < nobs; n++) begin
                tests++;
                if (obs[n] !== model(d, int'(l), n)) begin
                    fails++;
                    $display("FAIL random t%0d c%0d d=%h l=%0d: got %b want %b",
                             t, n, d, l, obs[n], model(d, int'(l), n));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_noop();
        test_back_to_back();
        test_capture();
        test_runlen();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have these ports, one per line, in this order:
  clk       input   1  single clock; all state changes on rising edge
  reset     input   1  asynchronous, active-low reset; 0 forces reset state immediately
  start     input   1  request to transmit; sampled in IDLE only
  data      input   8  pattern word; bit 0 sent first
  len       input   4  number of bits to send; 1..8 valid, 0 = no-op, 9..15 clamped to 8
  w         output  1  serial pattern bit (drives a detector's w input)
  w_valid   output  1  high while w carries a pattern bit
  busy      output  1  high from LOAD through DONE inclusive
  done      output  1  one-cycle pulse in DONE
  txState   output  2  current binary-encoded state
  run_len   output  4  consecutive-equal-bit count (see Configuration)
  run_hit   output  1  run-length marker (see Configuration)
REQ-002 The block SHALL have no parameters; the clock SHALL be clk and the reset SHALL be reset, asynchronous and active-low.

Function
REQ-003 The FSM SHALL use binary encoding: IDLE=00, LOAD=01, SHIFT=10, DONE=11, visible on txState.
REQ-004 In IDLE with start=1 and len!=0, the next state SHALL be LOAD; data and the clamped len SHALL be captured into internal registers on that same edge.
REQ-005 In IDLE with start=1 and len=0, the block SHALL remain in IDLE and capture nothing.
REQ-006 LOAD SHALL last exactly one cycle: w=0, w_valid=0, busy=1, bit index cleared to 0; next state SHALL be SHIFT.
REQ-007 In SHIFT cycle k (k=0..L-1, L=captured length), w SHALL equal captured data[k], w_valid=1, busy=1.
REQ-008 After SHIFT cycle L-1, the next state SHALL be DONE; DONE SHALL last one cycle with done=1, busy=1, w=0, w_valid=0, then return to IDLE.
REQ-009 A transfer SHALL keep busy high for exactly L+2 cycles; start SHALL be ignored whenever txState!=IDLE, including in DONE.
REQ-010 Changes to data or len after capture SHALL NOT affect the transfer in progress.
REQ-011 In IDLE, w, w_valid, busy and done SHALL all be 0.
REQ-012 The bit index SHALL be 3 bits wide and SHALL NOT wrap within a transfer (max L=8 -> index 0..7).

Reset
REQ-013 While reset=0, the state SHALL be IDLE and every output and internal register SHALL be 0, independent of clk.
REQ-014 Reset asserted mid-transfer SHALL abort it with no done pulse; after release, the block SHALL accept a new start on the first rising edge.

Configuration
REQ-015 Macro PATTERN_TX_RUNLEN_EN SHALL select the run-length monitor.
REQ-016 With PATTERN_TX_RUNLEN_EN defined: run_len SHALL be 1 on the first SHIFT cycle, increment (saturating at 15) each SHIFT cycle in which w equals the previous SHIFT-cycle w, and reset to 1 on a change; it SHALL be 0 outside SHIFT.
REQ-017 With PATTERN_TX_RUNLEN_EN defined: run_hit SHALL be 1 in every SHIFT cycle where run_len>=2, else 0.
REQ-018 Without PATTERN_TX_RUNLEN_EN: run_len SHALL be tied to 0 and run_hit to 0, and no run-length registers SHALL exist.

Verification
REQ-019 Reset: reset=0 mid-SHIFT of data=8'hFF,len=8 -> txState=00, all outputs 0 immediately, no done pulse.
REQ-020 Basic: data=8'b1011_0010, len=8, start pulse -> LOAD, then w=0,1,0,0,1,1,0,1 with w_valid=1 over 8 cycles, done=1 one cycle, busy high 10 cycles.
REQ-021 Short/clamp: len=3 data=8'h05 -> w=1,0,1; len=12 data=8'h0F -> 8 bits sent 1,1,1,1,0,0,0,0.
REQ-022 No-op and busy: start with len=0 -> stays IDLE; start held high through a whole transfer -> second transfer starts only from IDLE, after DONE.
REQ-023 Capture stability: change data and len during SHIFT -> transmitted bits match the values captured at start.
REQ-024 Run monitor (macro defined): data=8'b0000_0111, len=8 -> run_len=1,2,3,1,2,3,4,5, run_hit=0,1,1,0,1,1,1,1; macro undefined -> run_len=0, run_hit=0 throughout.
